// File: rtl/lemming_dig_arbiter.sv
// ---------------------------------------------------------------------------
// lemming_dig_arbiter
//
// Shares the level's single dig skill among NUM_LEMMINGS lemming walker FSMs.
// A player dig request for lemming i only counts if that lemming is eligible
// (walking on ground). Valid requests are granted round-robin. Each grant
// sends a one-cycle dig pulse, uses one unit of a finite dig budget, and is
// followed by COOLDOWN idle cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   areset_n     in   asynchronous active-low reset
//   req          in   [NUM_LEMMINGS] level dig request per lemming
//   eligible     in   [NUM_LEMMINGS] lemming is walking with ground under it
//   budget_load  in   load budget from budget_value at the next edge
//   budget_value in   [BUDGET_W] budget load value
//   dig          out  [NUM_LEMMINGS] one-hot dig pulse (or all zero)
//   grant_id     out  [clog2(NUM_LEMMINGS)] index of the most recent grant
//   busy         out  high while in GRANT or COOLDOWN
//   budget       out  [BUDGET_W] remaining digs
//   denied       out  a valid request was refused because the budget is 0
// ---------------------------------------------------------------------------
module lemming_dig_arbiter #(
  parameter int NUM_LEMMINGS = 4,
  parameter int BUDGET_W     = 4,
  parameter int COOLDOWN     = 3,
  localparam int IDW         = (NUM_LEMMINGS > 1) ? $clog2(NUM_LEMMINGS) : 1
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic [NUM_LEMMINGS-1:0] req,
  input  logic [NUM_LEMMINGS-1:0] eligible,
  input  logic                    budget_load,
  input  logic [BUDGET_W-1:0]     budget_value,
  output logic [NUM_LEMMINGS-1:0] dig,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic [BUDGET_W-1:0]     budget,
  output logic                    denied
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_COOL  = 2'd2
  } state_e;

  // Cooldown counter start value; unused when COOLDOWN is zero.
  localparam logic [3:0] CD_INIT = (COOLDOWN > 0) ? 4'(COOLDOWN - 1) : 4'd0;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_LEMMINGS - 1);

  state_e                  state_q;
  logic [NUM_LEMMINGS-1:0] dig_q;
  logic [IDW-1:0]          grant_id_q;
  logic [IDW-1:0]          ptr_q;
  logic                    busy_q;
  logic [BUDGET_W-1:0]     budget_q;
  logic [BUDGET_W-1:0]     budget_d;
  logic                    denied_q;
  logic [3:0]              cnt_q;

  logic [NUM_LEMMINGS-1:0] valid_s;
  logic                    pick_found_s;
  logic [IDW-1:0]          pick_idx_s;
  logic [IDW-1:0]          ptr_d;
  logic [NUM_LEMMINGS-1:0] onehot_s;
  logic                    grant_s;

  // Round-robin search: first set bit of v at or after ptr, wrapping.
  // Scanning from the farthest offset down lets the nearest hit win last.
  // Returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_LEMMINGS-1:0] v,
                                           input logic [IDW-1:0]          ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NUM_LEMMINGS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_LEMMINGS) begin
        idx = idx - NUM_LEMMINGS;
      end
      if (v[idx]) begin
        res = {1'b1, idx[IDW-1:0]};
      end
    end
    return res;
  endfunction

  // Request qualification, round-robin pick and budget next-state.
  always_comb begin
    valid_s                    = req & eligible;
    {pick_found_s, pick_idx_s} = rr_pick(valid_s, ptr_q);
    grant_s  = (state_q == ST_IDLE) && pick_found_s && (budget_q != '0);
    onehot_s = {{(NUM_LEMMINGS-1){1'b0}}, 1'b1} << pick_idx_s;
    if (pick_idx_s == LAST_IDX) begin
      ptr_d = '0;
    end else begin
      ptr_d = pick_idx_s + 1'b1;
    end
    // A load wins over a same-cycle grant decrement; the grant still happens.
    if (budget_load) begin
      budget_d = budget_value;
    end else if (grant_s) begin
      budget_d = budget_q - 1'b1;
    end else begin
      budget_d = budget_q;
    end
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      dig_q      <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      budget_q   <= '0;
      denied_q   <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      budget_q <= budget_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            state_q    <= ST_GRANT;
            grant_id_q <= pick_idx_s;
            ptr_q      <= ptr_d;
            dig_q      <= onehot_s;
            busy_q     <= 1'b1;
            denied_q   <= 1'b0;
          end else begin
            // Outside a grant, a found request can only mean budget is 0.
            state_q  <= ST_IDLE;
            dig_q    <= '0;
            busy_q   <= 1'b0;
            denied_q <= pick_found_s;
          end
        end
        ST_GRANT: begin
          dig_q    <= '0;
          denied_q <= 1'b0;
          if (COOLDOWN == 0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_COOL;
            cnt_q   <= CD_INIT;
            busy_q  <= 1'b1;
          end
        end
        ST_COOL: begin
          dig_q    <= '0;
          denied_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          dig_q    <= '0;
          busy_q   <= 1'b0;
          denied_q <= 1'b0;
          cnt_q    <= 4'd0;
        end
      endcase
    end
  end

  assign dig      = dig_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign budget   = budget_q;
  assign denied   = denied_q;

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
module tb_lemming_dig_arbiter;
  localparam int N  = 4;
  localparam int BW = 4;
  localparam int CD = 3;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  eligible = '0;
  logic          budget_load = 1'b0;
  logic [BW-1:0] budget_value = '0;
  logic [N-1:0]  dig;
  logic [1:0]    grant_id;
  logic          busy;
  logic [BW-1:0] budget;
  logic          denied;

  int n_checks = 0;
  int n_fail   = 0;

  lemming_dig_arbiter #(.NUM_LEMMINGS(N), .BUDGET_W(BW), .COOLDOWN(CD)) dut (
    .clk(clk), .areset_n(areset_n), .req(req), .eligible(eligible),
    .budget_load(budget_load), .budget_value(budget_value),
    .dig(dig), .grant_id(grant_id), .busy(busy), .budget(budget),
    .denied(denied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] elig;
    logic       load;
    logic [3:0] val;
    logic [3:0] e_dig;
    logic       e_busy;
    logic [3:0] e_budget;
    logic       e_denied;
    logic [1:0] e_gid;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset_n     = 1'b0;
    req          = '0;
    eligible     = '0;
    budget_load  = 1'b0;
    budget_value = '0;
    repeat (2) @(posedge clk);
    #3;
    areset_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_dig, input logic e_busy,
                         input logic [3:0] e_bud, input logic e_den, input logic [1:0] e_gid);
    chk({tag, "_dig"},    32'(dig),      32'(e_dig));
    chk({tag, "_busy"},   32'(busy),     32'(e_busy));
    chk({tag, "_budget"}, 32'(budget),   32'(e_bud));
    chk({tag, "_denied"}, 32'(denied),   32'(e_den));
    chk({tag, "_gid"},    32'(grant_id), 32'(e_gid));
  endtask

  // Reference model state: hold = number of busy cycles still ahead,
  // counting the current one.
  int m_budget, m_ptr, m_gid, m_hold, e_dig, e_den, e_busy;

  task automatic model_step();
    int v, pick;
    v    = int'(req & eligible);
    pick = -1;
    e_dig = 0;
    e_den = 0;
    if (m_hold == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (((v >> idx) & 1) == 1 && pick < 0) pick = idx;
      end
      if (pick >= 0 && m_budget > 0) begin
        e_dig    = 1 << pick;
        m_gid    = pick;
        m_ptr    = (pick + 1) % N;
        m_budget = budget_load ? int'(budget_value) : m_budget - 1;
        m_hold   = CD + 1;
      end else begin
        e_den = (pick >= 0) ? 1 : 0;
        if (budget_load) m_budget = int'(budget_value);
      end
    end else begin
      m_hold = m_hold - 1;
      if (budget_load) m_budget = int'(budget_value);
    end
    e_busy = (m_hold > 0) ? 1 : 0;
  endtask

  initial begin
    // Budget 5, lemming 0 requests: pulse, 4 busy cycles, next pulse 5 later;
    // then the eligibility gate on lemming 1.
    tbl[0]  = '{4'b0000, 4'b1111, 1'b1, 4'd5, 4'b0000, 1'b0, 4'd5, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 4'b1111, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd4, 1'b0, 2'd0};
    tbl[2]  = '{4'b0001, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd4, 1'b0, 2'd0};
    tbl[3]  = '{4'b0001, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd4, 1'b0, 2'd0};
    tbl[4]  = '{4'b0001, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd4, 1'b0, 2'd0};
    tbl[5]  = '{4'b0001, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd4, 1'b0, 2'd0};
    tbl[6]  = '{4'b0001, 4'b1111, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd3, 1'b0, 2'd0};
    tbl[7]  = '{4'b0000, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd3, 1'b0, 2'd0};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd3, 1'b0, 2'd0};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd3, 1'b0, 2'd0};
    tbl[10] = '{4'b0000, 4'b1111, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd3, 1'b0, 2'd0};
    tbl[11] = '{4'b0010, 4'b1101, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd3, 1'b0, 2'd0};
    tbl[12] = '{4'b0010, 4'b1101, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd3, 1'b0, 2'd0};
    tbl[13] = '{4'b0010, 4'b1111, 1'b0, 4'd0, 4'b0010, 1'b1, 4'd2, 1'b0, 2'd1};

    // ---- reset values ----
    do_reset();
    chk_all("reset", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);

    // ---- table vectors ----
    for (int i = 0; i < 14; i++) begin
      req          = tbl[i].req;
      eligible     = tbl[i].elig;
      budget_load  = tbl[i].load;
      budget_value = tbl[i].val;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].e_dig, tbl[i].e_busy,
              tbl[i].e_budget, tbl[i].e_denied, tbl[i].e_gid);
    end

    // ---- ineligible request held for 10 cycles: nothing happens ----
    do_reset();
    budget_load = 1'b1; budget_value = 4'd3; cyc(); budget_load = 1'b0;
    req = 4'b0010; eligible = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("elig_dig", 32'(dig), 32'd0);
      chk("elig_denied", 32'(denied), 32'd0);
    end
    eligible = 4'b1111;
    cyc();
    chk("elig_grant", 32'(dig), 32'b0010);

    // ---- round robin with all requesting ----
    begin
      logic [3:0] exp_seq[5];
      int         exp_g[5];
      int         np, last;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_g   = '{0, 1, 2, 3, 0};
      np = 0; last = -1;
      do_reset();
      budget_load = 1'b1; budget_value = 4'd8; eligible = 4'b1111; cyc();
      budget_load = 1'b0; req = 4'b1111;
      for (int c = 0; c < 60 && np < 5; c++) begin
        cyc();
        if (dig != 4'b0000) begin
          chk("rr_dig", 32'(dig), 32'(exp_seq[np]));
          chk("rr_gid", 32'(grant_id), exp_g[np]);
          if (last >= 0) chk("rr_spacing", c - last, 5);
          last = c;
          np++;
          if (np == 5) req = 4'b0000;
        end
      end
      chk("rr_count", np, 5);
      repeat (6) cyc();
      chk("rr_budget", 32'(budget), 32'd3);
    end

    // ---- budget exhaustion and reload ----
    do_reset();
    budget_load = 1'b1; budget_value = 4'd1; eligible = 4'b1111; cyc();
    budget_load = 1'b0; req = 4'b0100;
    cyc();
    chk("exh_dig", 32'(dig), 32'b0100);
    chk("exh_budget0", 32'(budget), 32'd0);
    repeat (5) cyc();
    for (int c = 0; c < 6; c++) begin
      chk("exh_denied", 32'(denied), 32'd1);
      chk("exh_budget", 32'(budget), 32'd0);
      chk("exh_nodig", 32'(dig), 32'd0);
      cyc();
    end
    budget_load = 1'b1; budget_value = 4'd2;
    cyc();
    budget_load = 1'b0;
    chk("exh_load", 32'(budget), 32'd2);
    cyc();
    chk("exh_resume_dig", 32'(dig), 32'b0100);
    chk("exh_resume_budget", 32'(budget), 32'd1);
    chk("exh_resume_denied", 32'(denied), 32'd0);

    // ---- load coinciding with a grant decision ----
    do_reset();
    budget_load = 1'b1; budget_value = 4'd2; eligible = 4'b1111; cyc();
    budget_value = 4'd7; req = 4'b0001;
    cyc();
    budget_load = 1'b0; req = 4'b0000;
    chk("coll_dig", 32'(dig), 32'b0001);
    chk("coll_budget", 32'(budget), 32'd7);

    // ---- asynchronous reset in cooldown ----
    do_reset();
    budget_load = 1'b1; budget_value = 4'd4; eligible = 4'b1111; cyc();
    budget_load = 1'b0; req = 4'b0010;
    cyc();
    chk("ar_pre_gid", 32'(grant_id), 32'd1);
    req = 4'b0000;
    cyc(); cyc();
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    areset_n = 1'b0;
    #1;
    chk_all("ar_now", 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0);
    cyc(); cyc();
    #2;
    areset_n = 1'b1;
    budget_load = 1'b1; budget_value = 4'd4;
    cyc();
    budget_load = 1'b0;
    chk("ar_post_dig", 32'(dig), 32'd0);
    chk("ar_post_busy", 32'(busy), 32'd0);
    // Pointer was 2 before reset; after reset the search starts at 0.
    req = 4'b1001;
    cyc();
    chk("ar_ptr_dig", 32'(dig), 32'b0001);
    chk("ar_ptr_gid", 32'(grant_id), 32'd0);
    req = 4'b0000;
    repeat (4) cyc();
    req = 4'b1000;
    cyc();
    chk("ar_gid3_dig", 32'(dig), 32'b1000);
    chk("ar_gid3_gid", 32'(grant_id), 32'd3);
    req = 4'b0000;

    // ---- randomized stimulus against the reference model ----
    do_reset();
    m_budget = 0; m_ptr = 0; m_gid = 0; m_hold = 0;
    for (int c = 0; c < 2000; c++) begin
      req          = 4'($urandom);
      eligible     = 4'($urandom) | 4'($urandom);
      budget_load  = ($urandom_range(0, 11) == 0);
      budget_value = 4'($urandom);
      model_step();
      cyc();
      chk("rnd_dig",    32'(dig),      e_dig);
      chk("rnd_busy",   32'(busy),     e_busy);
      chk("rnd_budget", 32'(budget),   m_budget);
      chk("rnd_denied", 32'(denied),   e_den);
      chk("rnd_gid",    32'(grant_id), m_gid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
